// File: rtl/arch_pkg.sv
// Architecture-wide instruction-type encoding shared by the decoder and the
// control blocks of the multi-cycle core.
package arch_pkg;

    localparam int unsigned ARCH_TYPE_NOP            = 0;
    localparam int unsigned ARCH_TYPE_LOAD           = 1;
    localparam int unsigned ARCH_TYPE_STORE          = 2;
    localparam int unsigned ARCH_TYPE_ALU            = 3;
    localparam int unsigned ARCH_TYPE_LOAD_IMMEDIATE = 4;
    localparam int unsigned ARCH_TYPE_JUMP           = 5;

endpackage

// File: rtl/stage_sequencer_pkg.sv
// Stage codes and per-type stage paths for the stage sequencer.
package stage_sequencer_pkg;

    import arch_pkg::*;

    localparam int STAGE_W = 3;

    typedef enum logic [STAGE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6,
        ST_ILLEGAL = 3'd7
    } stage_e;

    // Which optional stages an instruction visits after DECODE; the last
    // visited stage is its retire stage (DECODE when none are set).
    typedef struct packed {
        logic exec;
        logic mem;
        logic wb;
    } path_t;

    localparam path_t PATH_LOAD  = '{exec: 1'b1, mem: 1'b1, wb: 1'b1};
    localparam path_t PATH_STORE = '{exec: 1'b1, mem: 1'b1, wb: 1'b0};
    localparam path_t PATH_ALU   = '{exec: 1'b1, mem: 1'b0, wb: 1'b1};
    localparam path_t PATH_LDI   = '{exec: 1'b0, mem: 1'b0, wb: 1'b1};
    localparam path_t PATH_JUMP  = '{exec: 1'b1, mem: 1'b0, wb: 1'b0};
    localparam path_t PATH_OTHER = '{exec: 1'b0, mem: 1'b0, wb: 1'b0};

    function automatic path_t path_of(input int unsigned itype);
        case (itype)
            ARCH_TYPE_LOAD:           path_of = PATH_LOAD;
            ARCH_TYPE_STORE:          path_of = PATH_STORE;
            ARCH_TYPE_ALU:            path_of = PATH_ALU;
            ARCH_TYPE_LOAD_IMMEDIATE: path_of = PATH_LDI;
            ARCH_TYPE_JUMP:           path_of = PATH_JUMP;
            default:                  path_of = PATH_OTHER;
        endcase
    endfunction

endpackage

// File: rtl/sat_wrap_counter.sv
// Enabled up-counter that wraps modulo 2^WIDTH, async active-low reset.
module sat_wrap_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    // Count enabled cycles; natural overflow gives the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: walks each instruction through only the
// stages its type needs, waits on mem_ready, honours halt requests at
// instruction boundaries and counts retirements.
// Optional macro STAGE_SEQ_PERF_EN adds stall_count and halt_count outputs.
module stage_sequencer
    import arch_pkg::*;
    import stage_sequencer_pkg::*;
#(
    parameter int TYPE_W     = 5,
    parameter int RETIRE_W   = 32,
    parameter int FETCH_WAIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TYPE_W-1:0]   instr_type,
    input  logic                jump_cond_nz,
    input  logic                mem_ready,
    input  logic                halt_req,
    output logic [STAGE_W-1:0]  stage,
    output logic                issue_en,
    output logic                pc_en,
    output logic                pc_jump,
    output logic                reg_we,
    output logic                mem_re,
    output logic                mem_we,
    output logic                halted,
    output logic [RETIRE_W-1:0] retire_count
`ifdef STAGE_SEQ_PERF_EN
    ,
    output logic [RETIRE_W-1:0] stall_count,
    output logic [RETIRE_W-1:0] halt_count
`endif
);

    stage_e stage_reg;
    path_t  path;
    logic   is_load;
    logic   is_store;
    logic   is_jump;
    logic   fetch_done;
    logic   retire;

    // Decode the current type and derive the handshake-dependent strobes.
    always_comb begin
        path       = path_of(32'(instr_type));
        is_load    = (instr_type == TYPE_W'(ARCH_TYPE_LOAD));
        is_store   = (instr_type == TYPE_W'(ARCH_TYPE_STORE));
        is_jump    = (instr_type == TYPE_W'(ARCH_TYPE_JUMP));
        fetch_done = (stage_reg == ST_FETCH) && ((FETCH_WAIT == 0) || mem_ready);
        retire     = 1'b0;
        case (stage_reg)
            ST_DECODE: retire = !path.exec && !path.wb;
            ST_EXEC:   retire = !path.mem && !path.wb;
            ST_MEM:    retire = mem_ready && !path.wb;
            ST_WB:     retire = 1'b1;
            default:   retire = 1'b0;
        endcase
        issue_en = fetch_done;
        pc_en    = retire;
        pc_jump  = retire && is_jump && jump_cond_nz;
        reg_we   = (stage_reg == ST_WB) && path.wb;
        mem_re   = (stage_reg == ST_MEM) && is_load;
        mem_we   = (stage_reg == ST_MEM) && is_store && mem_ready;
        halted   = (stage_reg == ST_HALT);
    end

    // Stage FSM; the retire cycle always ends the instruction, in any stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_reg <= ST_IDLE;
        end else if (retire) begin
            stage_reg <= halt_req ? ST_HALT : ST_FETCH;
        end else begin
            case (stage_reg)
                ST_IDLE:   stage_reg <= ST_FETCH;
                ST_FETCH:  if (fetch_done) stage_reg <= ST_DECODE;
                ST_DECODE: stage_reg <= path.exec ? ST_EXEC : ST_WB;
                ST_EXEC:   stage_reg <= path.mem ? ST_MEM : ST_WB;
                ST_MEM:    if (mem_ready) stage_reg <= ST_WB;
                ST_HALT:   if (!halt_req) stage_reg <= ST_FETCH;
                default:   stage_reg <= ST_IDLE;
            endcase
        end
    end

    assign stage = stage_reg;

    sat_wrap_counter #(.WIDTH(RETIRE_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (retire),
        .count (retire_count)
    );

`ifdef STAGE_SEQ_PERF_EN
    logic stall_en;
    logic halt_en;

    assign stall_en = ((stage_reg == ST_FETCH) || (stage_reg == ST_MEM)) && !mem_ready;
    assign halt_en  = (stage_reg == ST_HALT);

    sat_wrap_counter #(.WIDTH(RETIRE_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (stall_en),
        .count (stall_count)
    );

    sat_wrap_counter #(.WIDTH(RETIRE_W)) u_halt_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (halt_en),
        .count (halt_count)
    );
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed scoreboard bench for stage_sequencer (default parameters).
module tb_stage_sequencer;

    import arch_pkg::*;

    localparam logic [4:0] T_NOP = 5'(ARCH_TYPE_NOP);
    localparam logic [4:0] T_LD  = 5'(ARCH_TYPE_LOAD);
    localparam logic [4:0] T_ST  = 5'(ARCH_TYPE_STORE);
    localparam logic [4:0] T_ALU = 5'(ARCH_TYPE_ALU);
    localparam logic [4:0] T_LI  = 5'(ARCH_TYPE_LOAD_IMMEDIATE);
    localparam logic [4:0] T_JMP = 5'(ARCH_TYPE_JUMP);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  instr_type = 5'd0;
    logic        jump_cond_nz = 1'b0;
    logic        mem_ready = 1'b1;
    logic        halt_req = 1'b0;
    logic [2:0]  stage;
    logic        issue_en, pc_en, pc_jump, reg_we, mem_re, mem_we, halted;
    logic [31:0] retire_count;
`ifdef STAGE_SEQ_PERF_EN
    logic [31:0] stall_count;
    logic [31:0] halt_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_cycle  = 0;

    // Expected per-cycle output: stage, strobes
    // {issue_en, pc_en, pc_jump, reg_we, mem_re, mem_we, halted}, retire_count.
    typedef struct {
        logic [2:0]  st;
        logic [6:0]  sb;
        logic [31:0] rc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    stage_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_type   (instr_type),
        .jump_cond_nz (jump_cond_nz),
        .mem_ready    (mem_ready),
        .halt_req     (halt_req),
        .stage        (stage),
        .issue_en     (issue_en),
        .pc_en        (pc_en),
        .pc_jump      (pc_jump),
        .reg_we       (reg_we),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .halted       (halted),
        .retire_count (retire_count)
`ifdef STAGE_SEQ_PERF_EN
        ,
        .stall_count  (stall_count),
        .halt_count   (halt_count)
`endif
    );

    // Monitor: pops one expectation per presented cycle; a retire with no
    // pending expectation is itself an error.
    always @(negedge clk) begin
        logic [6:0] sb_act;
        exp_t e;
        sb_act = {issue_en, pc_en, pc_jump, reg_we, mem_re, mem_we, halted};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (stage !== e.st || sb_act !== e.sb || retire_count !== e.rc) begin
                n_fail++;
                $display("FAIL trace[%0d]: got stage=%0d strobes=%b rc=%0d, want stage=%0d strobes=%b rc=%0d",
                         n_cycle, stage, sb_act, retire_count, e.st, e.sb, e.rc);
            end else begin
                $display("ok   trace[%0d]: stage=%0d strobes=%b rc=%0d", n_cycle, stage, sb_act, retire_count);
            end
            n_cycle++;
        end else if (pc_en) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_retire: got pc_en=1, want no activity");
        end
    end

    // One cycle of stimulus plus the expected response for that cycle.
    task automatic cyc(input logic r, input logic [4:0] t, input logic j, input logic m,
                       input logic h, input logic [2:0] st, input logic [6:0] sb, input int rc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; instr_type = t; jump_cond_nz = j; mem_ready = m; halt_req = h;
        e.st = st; e.sb = sb; e.rc = 32'(rc);
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset held, then ALU: 0,1,2,3,5,1
        cyc(0, T_ALU, 0, 1, 0, 3'd0, 7'b0000000, 0);
        cyc(0, T_ALU, 0, 1, 0, 3'd0, 7'b0000000, 0);
        cyc(1, T_ALU, 0, 1, 0, 3'd0, 7'b0000000, 0);
        cyc(1, T_ALU, 0, 1, 0, 3'd1, 7'b1000000, 0);
        cyc(1, T_ALU, 0, 1, 0, 3'd2, 7'b0000000, 0);
        cyc(1, T_ALU, 0, 1, 0, 3'd3, 7'b0000000, 0);
        cyc(1, T_ALU, 0, 1, 0, 3'd5, 7'b0101000, 0);
        // LOAD with three waiting MEM cycles
        cyc(1, T_LD,  0, 1, 0, 3'd1, 7'b1000000, 1);
        cyc(1, T_LD,  0, 0, 0, 3'd2, 7'b0000000, 1);
        cyc(1, T_LD,  0, 0, 0, 3'd3, 7'b0000000, 1);
        cyc(1, T_LD,  0, 0, 0, 3'd4, 7'b0000100, 1);
        cyc(1, T_LD,  0, 0, 0, 3'd4, 7'b0000100, 1);
        cyc(1, T_LD,  0, 0, 0, 3'd4, 7'b0000100, 1);
        cyc(1, T_LD,  0, 1, 0, 3'd4, 7'b0000100, 1);
        cyc(1, T_LD,  0, 1, 0, 3'd5, 7'b0101000, 1);
        // STORE with mem_ready 0,0,1 in MEM
        cyc(1, T_ST,  0, 1, 0, 3'd1, 7'b1000000, 2);
        cyc(1, T_ST,  0, 0, 0, 3'd2, 7'b0000000, 2);
        cyc(1, T_ST,  0, 0, 0, 3'd3, 7'b0000000, 2);
        cyc(1, T_ST,  0, 0, 0, 3'd4, 7'b0000000, 2);
        cyc(1, T_ST,  0, 0, 0, 3'd4, 7'b0000000, 2);
        cyc(1, T_ST,  0, 1, 0, 3'd4, 7'b0100010, 2);
        // JUMP taken, with one FETCH wait cycle
        cyc(1, T_JMP, 1, 0, 0, 3'd1, 7'b0000000, 3);
        cyc(1, T_JMP, 1, 1, 0, 3'd1, 7'b1000000, 3);
        cyc(1, T_JMP, 1, 1, 0, 3'd2, 7'b0000000, 3);
        cyc(1, T_JMP, 1, 1, 0, 3'd3, 7'b0110000, 3);
        // JUMP not taken
        cyc(1, T_JMP, 0, 1, 0, 3'd1, 7'b1000000, 4);
        cyc(1, T_JMP, 0, 1, 0, 3'd2, 7'b0000000, 4);
        cyc(1, T_JMP, 0, 1, 0, 3'd3, 7'b0100000, 4);
        // LOAD_IMMEDIATE: F D W
        cyc(1, T_LI,  0, 1, 0, 3'd1, 7'b1000000, 5);
        cyc(1, T_LI,  0, 1, 0, 3'd2, 7'b0000000, 5);
        cyc(1, T_LI,  0, 1, 0, 3'd5, 7'b0101000, 5);
        // Other type retires in DECODE
        cyc(1, T_NOP, 0, 1, 0, 3'd1, 7'b1000000, 6);
        cyc(1, T_NOP, 0, 1, 0, 3'd2, 7'b0100000, 6);
        // ALU with halt_req raised in DECODE, then HALT until it drops
        cyc(1, T_ALU, 0, 1, 0, 3'd1, 7'b1000000, 7);
        cyc(1, T_ALU, 0, 1, 1, 3'd2, 7'b0000000, 7);
        cyc(1, T_ALU, 0, 1, 1, 3'd3, 7'b0000000, 7);
        cyc(1, T_ALU, 0, 1, 1, 3'd5, 7'b0101000, 7);
        cyc(1, T_ALU, 0, 1, 1, 3'd6, 7'b0000001, 8);
        cyc(1, T_ALU, 0, 1, 1, 3'd6, 7'b0000001, 8);
        cyc(1, T_ALU, 0, 1, 0, 3'd6, 7'b0000001, 8);
        // LOAD interrupted by reset in MEM
        cyc(1, T_LD,  0, 1, 0, 3'd1, 7'b1000000, 8);
        cyc(1, T_LD,  0, 1, 0, 3'd2, 7'b0000000, 8);
        cyc(1, T_LD,  0, 1, 0, 3'd3, 7'b0000000, 8);
        cyc(1, T_LD,  0, 0, 0, 3'd4, 7'b0000100, 8);
`ifdef STAGE_SEQ_PERF_EN
        @(negedge clk);
        n_checks++;
        if (stall_count !== 32'd6 || halt_count !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_before_rst: got stall=%0d halt=%0d, want stall=6 halt=3", stall_count, halt_count);
        end
`endif
        cyc(0, T_LD,  0, 0, 0, 3'd0, 7'b0000000, 0);
`ifdef STAGE_SEQ_PERF_EN
        @(negedge clk);
        n_checks++;
        if (stall_count !== 32'd0 || halt_count !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_after_rst: got stall=%0d halt=%0d, want 0 0", stall_count, halt_count);
        end
`endif
        // Recovery after reset
        cyc(1, T_ALU, 0, 1, 0, 3'd0, 7'b0000000, 0);
        cyc(1, T_ALU, 0, 1, 0, 3'd1, 7'b1000000, 0);
        cyc(1, T_ALU, 0, 1, 0, 3'd2, 7'b0000000, 0);
        cyc(1, T_ALU, 0, 1, 0, 3'd3, 7'b0000000, 0);
        cyc(1, T_ALU, 0, 1, 0, 3'd5, 7'b0101000, 0);
        cyc(1, T_ALU, 0, 1, 0, 3'd1, 7'b1000000, 1);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised successor to the fixed modulo stage counter in the multi-cycle core.
- Steps each instruction through only the stages its type needs, and waits on a memory ready handshake instead of assuming single-cycle memory.
- Supports a halt request at instruction boundaries and counts retired instructions.
- Sits between the decoder and the PC, issue-register, register-file and main-memory control blocks, and drives their enables directly.

Parameters:
TYPE_W, 5, width of the instruction-type field from the decoder.
RETIRE_W, 32, width of the retired-instruction counter.
FETCH_WAIT, 1, 1 = FETCH holds until mem_ready; 0 = FETCH always lasts exactly one cycle.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
instr_type  input  TYPE_W  decoded type of the instruction currently in the issue register.
jump_cond_nz  input  1  jump condition register value is non-zero.
mem_ready  input  1  main memory completes the current access this cycle.
halt_req  input  1  request to stop at the next instruction boundary.
stage  output  3  current stage code.
issue_en  output  1  load the issue register.
pc_en  output  1  update the PC (retire cycle).
pc_jump  output  1  PC source is the jump address rather than PC+1.
reg_we  output  1  register-file write enable.
mem_re  output  1  data read in progress.
mem_we  output  1  data write strobe.
halted  output  1  sequencer is in HALT.
retire_count  output  RETIRE_W  number of instructions retired.

Behaviour:
- Stage codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is illegal and returns to IDLE on the next cycle.
- Reset (rst low, asynchronous):
  - stage=IDLE, retire_count=0.
  - All strobes 0 for the whole time rst is low.
  - The first cycle after release is IDLE, the second is FETCH.
  - Reset asserted mid-instruction abandons it: no pc_en, no retire_count increment.
- Strobes are combinational from stage, instr_type and the handshake inputs.
- FETCH:
  - issue_en=1 on the cycle FETCH exits (mem_ready=1, or any cycle when FETCH_WAIT=0).
  - Next stage is DECODE.
- Stage paths by type (type codes come from the shared arch defines):
  - LOAD: F D E M W.
  - STORE: F D E M, retires in M.
  - ALU: F D E W.
  - LOAD_IMMEDIATE: F D W.
  - JUMP: F D E, retires in E.
  - Any other type: F D, retires in D.
- MEM:
  - Holds while mem_ready=0.
  - LOAD: mem_re=1 in every MEM cycle.
  - STORE: mem_we=1 only in the MEM cycle where mem_ready=1, so exactly one write pulse.
- WB: reg_we=1 for exactly one cycle, for LOAD, ALU and LOAD_IMMEDIATE only.
- Retire cycle:
  - pc_en=1, retire_count increments, wrapping modulo 2^RETIRE_W.
  - pc_jump = (type==JUMP) & jump_cond_nz.
  - Next stage is HALT if halt_req=1, else FETCH.
- HALT:
  - halted=1, all strobes 0.
  - Returns to FETCH the cycle after halt_req is sampled low.
- halt_req has no effect before the retire cycle; an in-flight instruction always completes.
- instr_type is sampled in every stage after FETCH. The decoder holds it stable because issue_en is low outside FETCH.

Optional Feature:
- Macro: STAGE_SEQ_PERF_EN.
- Defined:
  - Adds outputs stall_count[RETIRE_W-1:0] and halt_count[RETIRE_W-1:0], both reset to 0 and wrapping.
  - stall_count increments on every FETCH or MEM cycle with mem_ready=0.
  - halt_count increments on every HALT cycle.
- Undefined: the ports and counters are absent, and the remaining behaviour is identical.

Decomposition:
- Shared package/defines: stage code constants, STAGE_W=3, and next-stage path constants.
- Instruction-type codes are reused from the existing arch defines, not duplicated.
- One sub-module: sat_wrap_counter (parametrised width, enable, async active-low reset), used for retire_count and the perf counters.

Test Plan:
- Release reset with mem_ready=1 and ALU type -> stage sequence 0,1,2,3,5,1; issue_en high in cycle 1, reg_we and pc_en high in cycle 5, retire_count=1.
- LOAD with mem_ready low for 3 MEM cycles -> mem_re high for 4 cycles, reg_we one cycle in WB, total 8 cycles after IDLE.
- STORE with mem_ready toggling 0,0,1 in MEM -> mem_we exactly one pulse on the third MEM cycle, reg_we never high, pc_en in that same cycle.
- JUMP with jump_cond_nz=1, then again with 0 -> pc_jump=1 and 0 respectively at EXEC retire; neither instruction enters MEM or WB.
- halt_req raised during DECODE of an ALU op -> instruction still retires; stage=6 and halted=1 until halt_req drops, then FETCH; retire_count unchanged during HALT.
- rst pulsed low during MEM of a LOAD -> stage=0 immediately, retire_count=0, no pc_en or reg_we pulse; with STAGE_SEQ_PERF_EN, stall_count=0.
